// File: rtl/regfile_sb.sv
// regfile_sb: multi-port integer register file with a per-register
// pending-write scoreboard for the pipelined core.
//   clk, rst      clock; synchronous active-low reset
//   rd_addr       NRD packed read addresses (port i at [i*AW +: AW])
//   rd_data       NRD packed read data (combinational)
//   rd_busy       per read port: register still has an outstanding write
//   wr_en/addr/data  NWR write ports, committed at posedge, highest index wins
//   iss_en/iss_addr  reserve a destination register (one more pending write)
//   iss_ready     reservation can be accepted this cycle
//   flush         clear all reservations at the next edge
//   busy_any      any register has a pending write
module regfile_sb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 2,
  parameter int unsigned BYPASS = 1,
  parameter int unsigned CNT_W  = 2,
  localparam int unsigned AW    = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*XLEN-1:0]  wr_data,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_addr,
  output logic                 iss_ready,
  input  logic                 flush,
  output logic                 busy_any
);

  localparam int unsigned WC_W  = $clog2(NWR + 1);
  localparam int unsigned SUM_W = ((CNT_W > WC_W) ? CNT_W : WC_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [XLEN-1:0]  mem     [NREG];
  logic [CNT_W-1:0] cnt     [NREG];
  logic [CNT_W-1:0] cnt_nxt [NREG];
  logic [WC_W-1:0]  wr_cnt  [NREG];
  logic [AW-1:0]    wa      [NWR];
  logic [XLEN-1:0]  wd      [NWR];
  logic             iss_acc;
  logic [SUM_W-1:0] up;
  logic [AW-1:0]    ra;
  logic [XLEN-1:0]  rv;

  // Unpack write ports
  for (genvar j = 0; j < NWR; j++) begin : g_wr_unpack
    assign wa[j] = wr_addr[j*AW +: AW];
    assign wd[j] = wr_data[j*XLEN +: XLEN];
  end

  // Issue is accepted only when the counter has headroom; x0 never counts
  assign iss_acc   = iss_en & iss_ready & (iss_addr != '0);
  assign iss_ready = rst & ((iss_addr == '0) | (cnt[iss_addr] != CNT_MAX));

  // Number of same-cycle writes targeting each register
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      wr_cnt[r] = '0;
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wa[j] == AW'(r))) wr_cnt[r] = wr_cnt[r] + WC_W'(1);
      end
    end
  end

  // Counter update: +issue -writes, floored at zero; flush clears all.
  // cnt+inc never exceeds CNT_MAX because issue is gated by iss_ready.
  always_comb begin
    up = '0;
    for (int r = 0; r < NREG; r++) begin
      up = SUM_W'(cnt[r]) + SUM_W'(iss_acc && (iss_addr == AW'(r)));
      if (flush || (r == 0))               cnt_nxt[r] = '0;
      else if (SUM_W'(wr_cnt[r]) >= up)    cnt_nxt[r] = '0;
      else                                 cnt_nxt[r] = CNT_W'(up - SUM_W'(wr_cnt[r]));
    end
  end

  // State: array and counters; later write ports override earlier ones
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        mem[r] <= '0;
        cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) cnt[r] <= cnt_nxt[r];
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wa[j] != '0)) mem[wa[j]] <= wd[j];
      end
    end
  end

  // Drain/fence indicator from current counters
  always_comb begin
    busy_any = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      if (cnt[r] != '0) busy_any = 1'b1;
    end
    if (!rst) busy_any = 1'b0;
  end

  // Read ports with optional write bypass; busy accounts for writes landing now
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    rv      = '0;
    for (int i = 0; i < NRD; i++) begin
      ra = rd_addr[i*AW +: AW];
      rv = mem[ra];
      if (BYPASS != 0) begin
        for (int j = 0; j < NWR; j++) begin
          if (wr_en[j] && (wa[j] == ra)) rv = wd[j];
        end
      end
      if (rst && (ra != '0)) begin
        rd_data[i*XLEN +: XLEN] = rv;
        if (BYPASS != 0) rd_busy[i] = SUM_W'(cnt[ra]) > SUM_W'(wr_cnt[ra]);
        else             rd_busy[i] = (cnt[ra] != '0);
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: one bypassing and one non-bypassing instance share
// all inputs; expected values are queued per step and compared each cycle.
module tb_regfile_sb;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREG  = 32;
  localparam int unsigned NRD   = 2;
  localparam int unsigned NWR   = 2;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned AW    = $clog2(NREG);

  localparam int F_RD0 = 0, F_RD1 = 1, F_BUSY0 = 2, F_BUSY1 = 3, F_ISSRDY = 4, F_BUSYANY = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic                flush;

  logic [NRD*XLEN-1:0] rd_data_b,  rd_data_n;
  logic [NRD-1:0]      rd_busy_b,  rd_busy_n;
  logic                iss_ready_b, iss_ready_n;
  logic                busy_any_b,  busy_any_n;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string           tag;
    int              inst;
    int              fld;
    logic [XLEN-1:0] val;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1), .CNT_W(CNT_W)) dut_b (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .iss_ready(iss_ready_b), .flush(flush), .busy_any(busy_any_b)
  );

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(0), .CNT_W(CNT_W)) dut_n (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .iss_ready(iss_ready_n), .flush(flush), .busy_any(busy_any_n)
  );

  // inst 0 = bypassing, 1 = non-bypassing, 2 = same value expected from both
  task automatic push_exp(input string tag, input int inst, input int fld, input logic [XLEN-1:0] val);
    exp_t e;
    e.tag = tag; e.fld = fld; e.val = val;
    if (inst == 2) begin
      e.inst = 0; exp_q.push_back(e);
      e.inst = 1; exp_q.push_back(e);
    end else begin
      e.inst = inst; exp_q.push_back(e);
    end
  endtask

  function automatic logic [XLEN-1:0] probe(input int inst, input int fld);
    logic [NRD*XLEN-1:0] d;
    logic [NRD-1:0]      b;
    logic                ir, ba;
    if (inst == 0) begin d = rd_data_b; b = rd_busy_b; ir = iss_ready_b; ba = busy_any_b; end
    else           begin d = rd_data_n; b = rd_busy_n; ir = iss_ready_n; ba = busy_any_n; end
    case (fld)
      F_RD0:    return d[XLEN-1:0];
      F_RD1:    return d[2*XLEN-1:XLEN];
      F_BUSY0:  return XLEN'(b[0]);
      F_BUSY1:  return XLEN'(b[1]);
      F_ISSRDY: return XLEN'(ir);
      default:  return XLEN'(ba);
    endcase
  endfunction

  task automatic clear_in();
    wr_en = '0; wr_data = '0; iss_en = 1'b0; flush = 1'b0;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input int p, input int a, input logic [XLEN-1:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = AW'(a);
    wr_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic test_reset();
    exp_t e; logic [XLEN-1:0] got;
    for (int s = 0; s < 4; s++) begin
      clear_in();
      case (s)
        0: begin
          rst = 1'b0; set_wr(0, 6, 32'h77); iss_en = 1'b1; iss_addr = AW'(6);
          set_rd(0, 6); set_rd(1, 6);
          push_exp("rst_rd0", 2, F_RD0, 0);       push_exp("rst_rd1", 2, F_RD1, 0);
          push_exp("rst_busy0", 2, F_BUSY0, 0);   push_exp("rst_busy1", 2, F_BUSY1, 0);
          push_exp("rst_issrdy", 2, F_ISSRDY, 0); push_exp("rst_busyany", 2, F_BUSYANY, 0);
        end
        1: begin
          rst = 1'b1; iss_addr = '0; set_rd(0, 5); set_rd(1, 0);
          push_exp("x5_after_rst", 2, F_RD0, 0);  push_exp("x0_after_rst", 2, F_RD1, 0);
          push_exp("x5_busy", 2, F_BUSY0, 0);     push_exp("x0_busy", 2, F_BUSY1, 0);
          push_exp("issrdy_x0", 2, F_ISSRDY, 1);  push_exp("busyany_idle", 2, F_BUSYANY, 0);
        end
        2: begin
          set_wr(0, 5, 32'hDEADBEEF); set_rd(0, 6); set_rd(1, 0);
          push_exp("x6_write_dropped_in_rst", 2, F_RD0, 0);
        end
        default: begin
          set_rd(0, 5); set_rd(1, 5);
          push_exp("x5_p0", 2, F_RD0, 32'hDEADBEEF); push_exp("x5_p1", 2, F_RD1, 32'hDEADBEEF);
        end
      endcase
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); got = probe(e.inst, e.fld); checks++;
        if (got !== e.val) begin
          errors++;
          $display("FAIL %s dut%0d: got %h expected %h", e.tag, e.inst, got, e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_multi_write();
    exp_t e; logic [XLEN-1:0] got;
    for (int s = 0; s < 3; s++) begin
      clear_in();
      set_rd(0, 7); set_rd(1, 7);
      case (s)
        0: begin
          set_wr(0, 7, 32'h33);
          push_exp("x7_first_byp", 0, F_RD0, 32'h33); push_exp("x7_first_nobyp", 1, F_RD0, 0);
        end
        1: begin
          set_wr(0, 7, 32'h11); set_wr(1, 7, 32'h22);
          push_exp("x7_hi_port_byp0", 0, F_RD0, 32'h22); push_exp("x7_hi_port_byp1", 0, F_RD1, 32'h22);
          push_exp("x7_old_nobyp0", 1, F_RD0, 32'h33);   push_exp("x7_old_nobyp1", 1, F_RD1, 32'h33);
        end
        default: begin
          push_exp("x7_array", 2, F_RD0, 32'h22); push_exp("x7_busyany", 2, F_BUSYANY, 0);
        end
      endcase
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); got = probe(e.inst, e.fld); checks++;
        if (got !== e.val) begin
          errors++;
          $display("FAIL %s dut%0d: got %h expected %h", e.tag, e.inst, got, e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_issue_sat();
    exp_t e; logic [XLEN-1:0] got;
    for (int s = 0; s < 8; s++) begin
      clear_in();
      set_rd(0, 3); set_rd(1, 3); iss_addr = AW'(3);
      case (s)
        0: begin iss_en = 1'b1; push_exp("x3_c0_busy", 2, F_BUSY0, 0); push_exp("x3_c0_rdy", 2, F_ISSRDY, 1); end
        1: begin iss_en = 1'b1; push_exp("x3_c1_busy", 2, F_BUSY0, 1); push_exp("x3_c1_any", 2, F_BUSYANY, 1); end
        2: begin iss_en = 1'b1; push_exp("x3_c2_rdy", 2, F_ISSRDY, 1); end
        3: begin
          iss_en = 1'b1;
          push_exp("x3_full_rdy", 2, F_ISSRDY, 0); push_exp("x3_full_busy", 2, F_BUSY1, 1);
          push_exp("x3_full_any", 2, F_BUSYANY, 1);
        end
        4: begin
          set_wr(0, 3, 32'hA1);
          push_exp("x3_w1_busy_byp", 0, F_BUSY0, 1); push_exp("x3_w1_data_byp", 0, F_RD0, 32'hA1);
          push_exp("x3_w1_data_nobyp", 1, F_RD0, 0); push_exp("x3_no_wrap_rdy", 2, F_ISSRDY, 0);
        end
        5: begin set_wr(0, 3, 32'hA2); push_exp("x3_w2_busy", 0, F_BUSY0, 1); push_exp("x3_w2_rdy", 2, F_ISSRDY, 1); end
        6: begin
          set_wr(1, 3, 32'hA3);
          push_exp("x3_last_busy_byp", 0, F_BUSY0, 0);  push_exp("x3_last_data_byp", 0, F_RD0, 32'hA3);
          push_exp("x3_last_busy_nobyp", 1, F_BUSY0, 1); push_exp("x3_last_data_nobyp", 1, F_RD0, 32'hA2);
          push_exp("x3_last_any", 2, F_BUSYANY, 1);
        end
        default: begin
          push_exp("x3_done_busy", 2, F_BUSY0, 0); push_exp("x3_done_any", 2, F_BUSYANY, 0);
          push_exp("x3_done_data", 2, F_RD0, 32'hA3);
        end
      endcase
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); got = probe(e.inst, e.fld); checks++;
        if (got !== e.val) begin
          errors++;
          $display("FAIL %s dut%0d: got %h expected %h", e.tag, e.inst, got, e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_iss_wr_same();
    exp_t e; logic [XLEN-1:0] got;
    for (int s = 0; s < 5; s++) begin
      clear_in();
      set_rd(0, 4); set_rd(1, 4); iss_addr = AW'(4);
      case (s)
        0: begin iss_en = 1'b1; push_exp("x4_c0_busy", 2, F_BUSY0, 0); end
        1: begin
          iss_en = 1'b1; set_wr(0, 4, 32'h44);
          push_exp("x4_net_busy_byp", 0, F_BUSY0, 0); push_exp("x4_net_busy_nobyp", 1, F_BUSY0, 1);
          push_exp("x4_net_data_byp", 0, F_RD0, 32'h44);
        end
        2: begin
          push_exp("x4_still1_busy", 2, F_BUSY0, 1); push_exp("x4_still1_any", 2, F_BUSYANY, 1);
          push_exp("x4_data", 2, F_RD1, 32'h44);
        end
        3: begin set_wr(1, 4, 32'h45); push_exp("x4_drain_byp", 0, F_BUSY0, 0); push_exp("x4_drain_nobyp", 1, F_BUSY0, 1); end
        default: begin push_exp("x4_idle_busy", 2, F_BUSY0, 0); push_exp("x4_idle_any", 2, F_BUSYANY, 0); end
      endcase
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); got = probe(e.inst, e.fld); checks++;
        if (got !== e.val) begin
          errors++;
          $display("FAIL %s dut%0d: got %h expected %h", e.tag, e.inst, got, e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush();
    exp_t e; logic [XLEN-1:0] got;
    for (int s = 0; s < 10; s++) begin
      clear_in();
      set_rd(0, 9); set_rd(1, 9); iss_addr = AW'(9);
      case (s)
        0: iss_en = 1'b1;
        1: begin iss_en = 1'b1; push_exp("x9_c1_busy", 2, F_BUSY0, 1); end
        2: begin
          flush = 1'b1; iss_en = 1'b1; set_wr(0, 9, 32'h55);
          push_exp("x9_c2_busy_byp", 0, F_BUSY0, 1); push_exp("x9_c2_any", 2, F_BUSYANY, 1);
          push_exp("x9_flush_data_byp", 0, F_RD0, 32'h55);
        end
        3: begin
          push_exp("x9_flushed_busy", 2, F_BUSY0, 0); push_exp("x9_flushed_any", 2, F_BUSYANY, 0);
          push_exp("x9_flush_commit", 2, F_RD0, 32'h55);
        end
        4: begin set_wr(1, 9, 32'h66); push_exp("x9_extra_busy", 2, F_BUSY0, 0); push_exp("x9_extra_byp", 0, F_RD0, 32'h66); end
        5: begin
          push_exp("x9_no_underflow_rdy", 2, F_ISSRDY, 1); push_exp("x9_no_underflow_busy", 2, F_BUSY0, 0);
          push_exp("x9_no_underflow_any", 2, F_BUSYANY, 0); push_exp("x9_extra_commit", 2, F_RD0, 32'h66);
        end
        6: begin iss_en = 1'b1; push_exp("x9_reissue_rdy", 2, F_ISSRDY, 1); end
        7: begin push_exp("x9_reissue_busy", 2, F_BUSY0, 1); push_exp("x9_reissue_any", 2, F_BUSYANY, 1); end
        8: begin set_wr(0, 9, 32'h67); push_exp("x9_final_byp", 0, F_BUSY0, 0); end
        default: push_exp("x9_final_any", 2, F_BUSYANY, 0);
      endcase
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); got = probe(e.inst, e.fld); checks++;
        if (got !== e.val) begin
          errors++;
          $display("FAIL %s dut%0d: got %h expected %h", e.tag, e.inst, got, e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_x0();
    exp_t e; logic [XLEN-1:0] got;
    for (int s = 0; s < 2; s++) begin
      clear_in();
      set_rd(0, 0); set_rd(1, 0); iss_addr = '0;
      case (s)
        0: begin
          set_wr(0, 0, 32'hFFFF); set_wr(1, 0, 32'h1234); iss_en = 1'b1;
          push_exp("x0_rdy", 2, F_ISSRDY, 1); push_exp("x0_byp_rd", 2, F_RD0, 0);
          push_exp("x0_busy", 2, F_BUSY0, 0); push_exp("x0_any", 2, F_BUSYANY, 0);
        end
        default: begin push_exp("x0_after", 2, F_RD1, 0); push_exp("x0_after_any", 2, F_BUSYANY, 0); end
      endcase
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); got = probe(e.inst, e.fld); checks++;
        if (got !== e.val) begin
          errors++;
          $display("FAIL %s dut%0d: got %h expected %h", e.tag, e.inst, got, e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    exp_t e; logic [XLEN-1:0] got;
    for (int s = 0; s < 5; s++) begin
      clear_in();
      set_rd(0, 1); set_rd(1, 2); iss_addr = AW'(1);
      case (s)
        0: begin iss_en = 1'b1; set_wr(1, 2, 32'hB2); end
        1: begin
          push_exp("x1_busy", 2, F_BUSY0, 1); push_exp("x2_data", 2, F_RD1, 32'hB2);
          push_exp("pre_rst_any", 2, F_BUSYANY, 1);
        end
        2: begin
          rst = 1'b0; iss_en = 1'b1; flush = 1'b1; set_wr(0, 2, 32'hC2);
          push_exp("mid_rst_rd0", 2, F_RD0, 0);  push_exp("mid_rst_rd1", 2, F_RD1, 0);
          push_exp("mid_rst_busy0", 2, F_BUSY0, 0); push_exp("mid_rst_rdy", 2, F_ISSRDY, 0);
          push_exp("mid_rst_any", 2, F_BUSYANY, 0);
        end
        3: begin
          rst = 1'b1;
          push_exp("post_rst_x1_busy", 2, F_BUSY0, 0); push_exp("post_rst_x2", 2, F_RD1, 0);
          push_exp("post_rst_any", 2, F_BUSYANY, 0);    push_exp("post_rst_rdy", 2, F_ISSRDY, 1);
        end
        default: begin
          set_rd(0, 5); set_rd(1, 7);
          push_exp("post_rst_x5", 2, F_RD0, 0); push_exp("post_rst_x7", 2, F_RD1, 0);
        end
      endcase
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); got = probe(e.inst, e.fld); checks++;
        if (got !== e.val) begin
          errors++;
          $display("FAIL %s dut%0d: got %h expected %h", e.tag, e.inst, got, e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; rd_addr = '0; wr_addr = '0; iss_addr = '0;
    clear_in();
    @(posedge clk); #1;
    test_reset();
    test_multi_write();
    test_issue_sat();
    test_iss_wr_same();
    test_flush();
    test_x0();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised multi-port integer register file with a per-register pending-write scoreboard, for the pipelined core.
- Decode reads operands and their busy status through NRD read ports, and reserves destination registers at issue.
- Writeback commits results through NWR write ports, with optional same-cycle write-to-read bypass.
- Replaces the fixed 2R/1W file and adds hazard tracking, so decode can stall without a separate scoreboard block.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of registers; register 0 is hardwired to zero; must be a power of 2, at least 2.
- NRD, 2, number of read ports.
- NWR, 2, number of write ports.
- BYPASS, 1, 1 = same-cycle write data is forwarded to the read ports; 0 = the array value is read.
- CNT_W, 2, width of each per-register outstanding-write counter.
- (local) AW = clog2(NREG).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- rd_addr  in  NRD*AW  read addresses; port i uses slice [i*AW +: AW].
- rd_data  out  NRD*XLEN  read data, combinational.
- rd_busy  out  NRD  1 = the register on read port i still has an outstanding write.
- wr_en  in  NWR  write enables.
- wr_addr  in  NWR*AW  write addresses.
- wr_data  in  NWR*XLEN  write data.
- iss_en  in  1  reserve register iss_addr, which gets one more outstanding write.
- iss_addr  in  AW  destination register to reserve.
- iss_ready  out  1  1 = the reservation can be accepted this cycle.
- flush  in  1  clear all reservations at the next edge.
- busy_any  out  1  OR of all nonzero counters; used for drain and fence.

Behaviour:
- Reset (rst=0 sampled at posedge):
  - All registers go to 0 and all counters go to 0.
  - While rst=0, the combinational outputs are forced: rd_data=0, rd_busy=0, iss_ready=0, busy_any=0.
- Register 0:
  - Reads return 0.
  - Writes to register 0 are dropped.
  - Issue to register 0 is accepted (iss_ready=1) and changes no counter.
- Write commit at posedge:
  - Every wr_en[j] with a nonzero address writes wr_data[j].
  - If several ports target the same address, the highest index j wins.
- Read (combinational):
  - Address 0 returns 0.
  - Otherwise, if BYPASS=1 and any wr_en[j] matches the address, return the data of the highest matching j.
  - Otherwise return the array value.
- Counters:
  - cnt[r] has CNT_W bits.
  - Accepted issue = iss_en & iss_ready & (iss_addr != 0).
  - Next value: cnt_next[r] = cnt[r] + (accepted issue to r) - (number of wr_en ports with address r).
  - If the decrement exceeds cnt[r] + inc, the result saturates at 0. This covers a write after flush or an unreserved write, and the data still commits.
  - Issue and write to the same register in one cycle net out.
- iss_ready = (iss_addr == 0) | (cnt[iss_addr] != 2^CNT_W - 1).
  - No incoming write credit is counted toward iss_ready, which keeps the path short.
- rd_busy[i]:
  - BYPASS=1: 1 when cnt[a] exceeds the number of same-cycle writes to a. A register whose last pending write lands this cycle reads not-busy, with the bypassed data.
  - BYPASS=0: 1 when cnt[a] != 0.
  - Address 0 always gives rd_busy=0.
- flush:
  - All counters become 0 at the next edge.
  - flush takes priority over issue and write decrements in that cycle.
  - Write data in the flush cycle still commits.
- busy_any uses the current counters, not cnt_next.
- rst=0 mid-operation overrides flush, issue and writes in the same cycle.

Test Plan:
- Reset, then read x5 and x0 on both ports -> rd_data=0, rd_busy=0. Write x5=0xDEADBEEF on port 0; next cycle read x5 -> 0xDEADBEEF.
- Write x7=0x11 on port 0 and x7=0x22 on port 1 in one cycle -> bypass read in that cycle =0x22; array value afterwards =0x22. Repeat with BYPASS=0 -> same-cycle read returns the old x7.
- Issue x3 three times (CNT_W=2) -> rd_busy=1 for x3, iss_ready=0 for x3, busy_any=1. Three writes to x3 -> the final write cycle shows rd_busy=0 (BYPASS=1), counter 0, busy_any=0.
- Issue x4 and write x4 in the same cycle with cnt=1 -> cnt stays 1, rd_busy stays 1.
- Issue x9 twice, then flush plus a write x9=0x55 in one cycle -> cnt=0, x9=0x55. A later extra write to x9 keeps cnt at 0 (no underflow).
- Write x0=0xFFFF and issue x0 -> x0 reads 0, iss_ready=1, busy_any=0. Assert rst=0 while x1 is busy -> all counters and registers 0 after the edge.
